// File: rtl/mpu_pkg.sv
// mpu_pkg: shared sequencer state encoding and widths for the MPU core
package mpu_pkg;
  localparam int PC_W_DEFAULT = 8;
  localparam int JMP_TGT_W = 4;
  typedef enum logic [1:0] {ST_RST, ST_RUN, ST_HALT, ST_STEP} state_t;
endpackage

// File: rtl/pc_next_logic.sv
// pc_next_logic: resolves the next program counter from jump controls and the zero flag
module pc_next_logic
  import mpu_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT
) (
  input  logic [PC_W-1:0]      pc,
  input  logic                 jmp,
  input  logic                 jmp_nz,
  input  logic [JMP_TGT_W-1:0] ir_nibble,
  input  logic                 zero_flag,
  output logic [PC_W-1:0]      pc_next
);
  // jmp dominates jmp_nz; jumps stay within the current 16-word page
  always_comb pc_next = (jmp | (jmp_nz & ~zero_flag)) ? {pc[PC_W-1:JMP_TGT_W], ir_nibble} : pc + 1'b1;
endmodule

// File: rtl/program_sequencer.sv
// program_sequencer: program counter, run/halt/step/breakpoint control and core reset sequencing
module program_sequencer
  import mpu_pkg::*;
#(
  parameter int PC_W         = PC_W_DEFAULT,
  parameter int RESET_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 jmp,
  input  logic                 jmp_nz,
  input  logic [JMP_TGT_W-1:0] ir_nibble,
  input  logic                 zero_flag,
  input  logic                 run_req,
  input  logic                 halt_req,
  input  logic                 step_req,
  input  logic                 bp_en,
  input  logic [PC_W-1:0]      bp_addr,
  output logic [PC_W-1:0]      pm_addr,
  output logic                 sync_reset,
  output logic                 core_en,
  output logic                 halted,
  output logic [CNT_W-1:0]     instr_cnt
);
  localparam int RC_W = $clog2(RESET_CYCLES + 1);
  state_t state, state_nx;
  logic [RC_W-1:0] rst_cnt;
  logic [PC_W-1:0] pc, pc_nx;
  logic bp_mask, bp_hit;
  assign pm_addr = pc;
  assign bp_hit = bp_en & ~bp_mask & (pc == bp_addr);
  pc_next_logic #(.PC_W(PC_W)) u_pc_next (
    .pc        (pc),
    .jmp       (jmp),
    .jmp_nz    (jmp_nz),
    .ir_nibble (ir_nibble),
    .zero_flag (zero_flag),
    .pc_next   (pc_nx)
  );
  // next state and core enable; a breakpoint hit blocks the enable in the same cycle
  always_comb begin
    state_nx = state;
    core_en  = 1'b0;
    case (state)
      ST_RST:  state_nx = (rst_cnt == RC_W'(RESET_CYCLES - 1)) ? ST_HALT : ST_RST;
      ST_HALT: state_nx = halt_req ? ST_HALT : run_req ? ST_RUN : step_req ? ST_STEP : ST_HALT;
      ST_STEP: begin
        core_en  = 1'b1;
        state_nx = ST_HALT;
      end
      ST_RUN: begin
        core_en  = ~bp_hit;
        state_nx = (bp_hit | halt_req) ? ST_HALT : ST_RUN;
      end
      default: state_nx = ST_RST;
    endcase
  end
  // state register with registered decodes so sync_reset and halted are glitch-free
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_RST;
      rst_cnt    <= '0;
      sync_reset <= 1'b1;
      halted     <= 1'b0;
      bp_mask    <= 1'b0;
    end else begin
      state      <= state_nx;
      rst_cnt    <= (state == ST_RST) ? rst_cnt + 1'b1 : rst_cnt;
      sync_reset <= (state_nx == ST_RST);
      halted     <= (state_nx == ST_HALT);
      bp_mask    <= (state == ST_HALT && state_nx == ST_RUN) ? 1'b1 : (state == ST_RUN) ? 1'b0 : bp_mask;
    end
  end
  // pc and retired count move only on enabled edges
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc        <= '0;
      instr_cnt <= '0;
    end else if (core_en) begin
      pc        <= pc_nx;
      instr_cnt <= instr_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: directed self-checking bench for program_sequencer
module tb_program_sequencer;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       jmp, jmp_nz, zero_flag, run_req, halt_req, step_req, bp_en;
  logic [3:0] ir_nibble;
  logic [7:0] bp_addr;
  logic [7:0] pm_addr;
  logic       sync_reset, core_en, halted;
  logic [15:0] instr_cnt;
  int checks = 0;
  int errors = 0;

  program_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .jmp        (jmp),
    .jmp_nz     (jmp_nz),
    .ir_nibble  (ir_nibble),
    .zero_flag  (zero_flag),
    .run_req    (run_req),
    .halt_req   (halt_req),
    .step_req   (step_req),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .pm_addr    (pm_addr),
    .sync_reset (sync_reset),
    .core_en    (core_en),
    .halted     (halted),
    .instr_cnt  (instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; jmp = 0; jmp_nz = 0; zero_flag = 0; ir_nibble = 4'h0;
    run_req = 0; halt_req = 0; step_req = 0; bp_en = 0; bp_addr = 8'h00;
    // reset held three cycles, then released
    repeat (3) tick();
    check("rst_sync", sync_reset, 1);
    check("rst_core_en", core_en, 0);
    check("rst_halted", halted, 0);
    check("rst_pm", pm_addr, 8'h00);
    check("rst_cnt", instr_cnt, 0);
    reset_n = 1'b1;
    tick();
    check("rstseq1_sync", sync_reset, 1);
    check("rstseq1_halted", halted, 0);
    tick();
    check("rstseq2_sync", sync_reset, 0);
    check("rstseq2_halted", halted, 1);
    check("rstseq2_pm", pm_addr, 8'h00);
    check("rstseq2_core_en", core_en, 0);
    // linear run through full wrap
    run_req = 1;
    tick();
    check("run_enter_core_en", core_en, 1);
    check("run_enter_pm", pm_addr, 8'h00);
    check("run_enter_halted", halted, 0);
    for (int k = 1; k <= 256; k++) begin
      tick();
      check("run_pm", pm_addr, k % 256);
      check("run_cnt", instr_cnt, k);
    end
    // halt retires the current instruction
    run_req = 0; halt_req = 1;
    tick();
    check("halt_pm", pm_addr, 8'h01);
    check("halt_halted", halted, 1);
    check("halt_core_en", core_en, 0);
    check("halt_cnt", instr_cnt, 257);
    halt_req = 0;
    // jumps within page 0x3_
    run_req = 1;
    tick();
    repeat (52) tick();
    check("pre_jmp_pm", pm_addr, 8'h35);
    jmp = 1; ir_nibble = 4'hA;
    tick();
    check("jmp_pm", pm_addr, 8'h3A);
    jmp = 0; jmp_nz = 1; zero_flag = 1;
    tick();
    check("jnz_z1_pm", pm_addr, 8'h3B);
    zero_flag = 0;
    tick();
    check("jnz_z0_pm", pm_addr, 8'h3A);
    jmp = 1; zero_flag = 1; ir_nibble = 4'h2;
    tick();
    check("jmp_both_pm", pm_addr, 8'h32);
    jmp = 0; jmp_nz = 0; zero_flag = 0;
    run_req = 0; halt_req = 1;
    tick();
    check("halt2_pm", pm_addr, 8'h33);
    check("halt2_cnt", instr_cnt, 314);
    halt_req = 0;
    // halt_req beats run_req in HALT
    run_req = 1; halt_req = 1;
    tick();
    check("prio_halted", halted, 1);
    check("prio_core_en", core_en, 0);
    check("prio_pm", pm_addr, 8'h33);
    run_req = 0; halt_req = 0;
    // single step
    step_req = 1;
    tick();
    step_req = 0;
    check("step_core_en", core_en, 1);
    check("step_halted", halted, 0);
    check("step_pm_before", pm_addr, 8'h33);
    tick();
    check("step_pm_after", pm_addr, 8'h34);
    check("step_halted_after", halted, 1);
    check("step_core_en_after", core_en, 0);
    tick();
    check("step_pm_hold", pm_addr, 8'h34);
    check("step_cnt", instr_cnt, 315);
    // breakpoint from a fresh reset
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
    tick();
    check("bp_pre_halted", halted, 1);
    bp_en = 1; bp_addr = 8'h05; run_req = 1;
    tick();
    repeat (5) tick();
    check("bp_hit_pm", pm_addr, 8'h05);
    check("bp_hit_core_en", core_en, 0);
    run_req = 0;
    tick();
    check("bp_halt_pm", pm_addr, 8'h05);
    check("bp_halt_halted", halted, 1);
    run_req = 1;
    tick();
    check("bp_resume_core_en", core_en, 1);
    tick();
    check("bp_resume_pm", pm_addr, 8'h06);
    tick();
    check("bp_resume_pm2", pm_addr, 8'h07);
    check("bp_resume_halted", halted, 0);
    check("bp_resume_cnt", instr_cnt, 7);
    // async reset mid-run
    repeat (64) tick();
    check("pre_areset_pm", pm_addr, 8'h47);
    check("pre_areset_cnt", instr_cnt, 16'h47);
    #2;
    reset_n = 1'b0;
    #1;
    check("areset_pm", pm_addr, 8'h00);
    check("areset_cnt", instr_cnt, 0);
    check("areset_sync", sync_reset, 1);
    check("areset_core_en", core_en, 0);
    check("areset_halted", halted, 0);
    run_req = 0; bp_en = 0;
    tick();
    reset_n = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
